compare_tracker: RTL and testbench
==================================

Name: compare_tracker

Overview:
- 4-bit step tracker that drives operand A of the 4-bit quadruple magnitude comparator and registers target B into it.
- Consumes the comparator's greater/smaller/equal flags and steps its counter by ±1 until A equals B.
- Connection: cnt → comparator a3..a0, tgt → comparator b3..b0, comparator aBIGGERb/aSMALLERb/aEQUALb → a_gt_b/a_lt_b/a_eq_b.
- The comparator is purely combinational, so flags are valid in the same cycle cnt/tgt change.

Parameters:
- DIV, 4, step prescale. One step decision every DIV clocks while tracking. Legal range 1..255; DIV=1 steps every cycle.
- CNT_INIT, 4'd0, counter value after reset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- load  input  1  capture target into tgt (IDLE or TRACK)
- target  input  4  new target value
- start  input  1  begin tracking (IDLE only)
- clear  input  1  synchronous clear of err/steps, returns to IDLE
- a_gt_b  input  1  comparator aBIGGERb
- a_lt_b  input  1  comparator aSMALLERb
- a_eq_b  input  1  comparator aEQUALb
- cnt  output  4  tracked value, to comparator A
- tgt  output  4  registered target, to comparator B
- busy  output  1  high in TRACK
- done  output  1  one-cycle pulse when tracking reaches equality
- err  output  1  sticky: comparator flags not one-hot at a tick
- steps  output  5  steps taken since start, saturates at 31

Behaviour:
- Reset (async, immediate, any state): state=IDLE, cnt=CNT_INIT, tgt=0, busy=0, done=0, err=0, steps=0, prescaler=0.
- States: IDLE, TRACK, DONE, ERR.
- IDLE:
  - load → tgt<=target.
  - start → TRACK, prescaler<=0, steps<=0.
  - load and start in the same cycle: both take effect, and the first tick sees the new tgt.
- TRACK:
  - busy=1. Prescaler counts 0..DIV-1; tick when prescaler==DIV-1, then prescaler wraps to 0.
  - On a tick, sample the flags:
    - a_eq_b only → DONE.
    - a_gt_b only → cnt<=cnt-1, steps+1.
    - a_lt_b only → cnt<=cnt+1, steps+1.
    - Any other combination → ERR, err<=1, cnt unchanged.
  - No tick → cnt holds.
  - load in TRACK → tgt<=target next edge, tracking continues, steps not cleared.
  - start in TRACK is ignored.
- DONE: done=1 for exactly this one cycle, busy=0, then IDLE unconditionally.
- ERR:
  - busy=0, err=1, cnt/tgt frozen. Only clear or rst exits.
  - clear → IDLE, err=0, steps=0, cnt unchanged.
- clear outside ERR: from TRACK or DONE → IDLE, steps=0, cnt holds; from IDLE → steps=0.
- clear has priority over load/start in the same cycle.
- cnt never wraps: it moves only toward tgt within 0..15. Increment at 15 or decrement at 0 is impossible with a correct comparator; if the flags demand it, treat it as an error (ERR).
- steps saturates at 31 (reachable only through repeated retargets).
- Latency: from entering TRACK to the first cnt change = DIV cycles. Equality detected at tick → done asserted next cycle.
- Reset mid-TRACK: all state returns to reset values immediately; no done pulse.

Optional Feature:
CMP_CHECK_EN
- Defined: one-hot check of a_gt_b/a_lt_b/a_eq_b on each tick as above; violation → ERR.
- Undefined: no ERR state, err tied 0, and ERR-state logic is removed. Priority on a tick is a_eq_b > a_gt_b > a_lt_b; all-zero flags → hold cnt, no step. The end-of-range guard is also removed.

Test Plan:
- DIV=1, CNT_INIT=0: load target=5 with start in the same cycle → cnt 1,2,3,4,5 on consecutive cycles; done pulses one cycle after cnt==5; steps=5.
- DIV=4, cnt=9: load 3, start → cnt decrements every 4th clock to 3; busy high throughout; steps=6; done is a single cycle.
- Retarget: tracking 0→12, load 2 when cnt==6 → cnt reverses to 2; steps=10.
- cnt==tgt==7 at start → done at the first tick (cycle DIV+1 after start); steps=0; cnt unchanged.
- CMP_CHECK_EN defined, force a_gt_b=a_lt_b=1 at a tick → err=1, cnt frozen; clear → IDLE, err=0.
- Assert rst mid-TRACK at cnt=4 → outputs go to reset values within the same cycle; no done; after release, load/start work normally.

Source files
------------

// File: rtl/compare_tracker.sv
`default_nettype none
// ============================================================================
// Module   : compare_tracker
// Brief    : Steps a 4-bit counter (comparator operand A) toward a registered
//            target (operand B) using the external comparator's flags.
//            Optional macro CMP_CHECK_EN enables the one-hot flag check and ERR.
// Revision : 1.0 - initial release
// ============================================================================
module compare_tracker #(
  parameter int         DIV      = 4,
  parameter logic [3:0] CNT_INIT = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] target,
  input  logic       start,
  input  logic       clear,
  input  logic       a_gt_b,
  input  logic       a_lt_b,
  input  logic       a_eq_b,
  output logic [3:0] cnt,
  output logic [3:0] tgt,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] steps
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam logic [7:0] c_divLast = 8'(DIV - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_presc;
  logic       w_tick;
  logic       w_stepUp;
  logic       w_stepDown;

  assign w_tick = (r_state == TRACK) && (r_presc == c_divLast);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_stepUp    = 1'b0;
    w_stepDown  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!clear && start) w_nextState = TRACK;
      end
      TRACK: begin
        if (clear) begin
          w_nextState = IDLE;
        end else if (w_tick) begin
`ifdef CMP_CHECK_EN
          // Flags must be one-hot; a step past either end of 0..15 is also a fault.
          case ({a_gt_b, a_lt_b, a_eq_b})
            3'b001:  w_nextState = DONE;
            3'b100: begin
              if (cnt == 4'd0) w_nextState = ERR;
              else             w_stepDown  = 1'b1;
            end
            3'b010: begin
              if (cnt == 4'd15) w_nextState = ERR;
              else              w_stepUp    = 1'b1;
            end
            default: w_nextState = ERR;
          endcase
`else
          if (a_eq_b)      w_nextState = DONE;
          else if (a_gt_b) w_stepDown  = 1'b1;
          else if (a_lt_b) w_stepUp    = 1'b1;
`endif
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
`ifdef CMP_CHECK_EN
        if (clear) w_nextState = IDLE;
`else
        w_nextState = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= CNT_INIT;
      tgt     <= 4'd0;
      steps   <= 5'd0;
      r_presc <= 8'd0;
    end else begin
      // Prescaler only runs while tracking, so every TRACK entry restarts at 0.
      if ((r_state == TRACK) && !clear && !w_tick) r_presc <= r_presc + 8'd1;
      else                                         r_presc <= 8'd0;

      if (load && !clear && ((r_state == IDLE) || (r_state == TRACK))) tgt <= target;

      if (w_stepUp)        cnt <= cnt + 4'd1;
      else if (w_stepDown) cnt <= cnt - 4'd1;

      if (clear || ((r_state == IDLE) && start))               steps <= 5'd0;
      else if ((w_stepUp || w_stepDown) && (steps != 5'd31)) steps <= steps + 5'd1;
    end
  end

  assign busy = (r_state == TRACK);
  assign done = (r_state == DONE);

`ifdef CMP_CHECK_EN
  assign err = (r_state == ERR);
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_compare_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_compare_tracker
// Brief    : Directed bench for compare_tracker with a behavioural comparator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_compare_tracker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance with DIV=1, CNT_INIT=0
  logic       ld1 = 1'b0, st1 = 1'b0, cl1 = 1'b0;
  logic [3:0] tv1 = 4'd0;
  logic       gt1, lt1, eq1;
  logic       frc1 = 1'b0;
  logic [2:0] fFlags1 = 3'b000;
  logic [3:0] cnt1, tgt1;
  logic       busy1, done1, err1;
  logic [4:0] steps1;

  // Instance with DIV=4, CNT_INIT=9
  logic       ld4 = 1'b0, st4 = 1'b0, cl4 = 1'b0;
  logic [3:0] tv4 = 4'd0;
  logic       gt4, lt4, eq4;
  logic [3:0] cnt4, tgt4;
  logic       busy4, done4, err4;
  logic [4:0] steps4;

  // Comparator model; fFlags1 is {gt, lt, eq} when forced
  always_comb begin
    if (frc1) begin
      {gt1, lt1, eq1} = fFlags1;
    end else begin
      gt1 = (cnt1 > tgt1);
      lt1 = (cnt1 < tgt1);
      eq1 = (cnt1 == tgt1);
    end
  end
  assign gt4 = (cnt4 > tgt4);
  assign lt4 = (cnt4 < tgt4);
  assign eq4 = (cnt4 == tgt4);

  compare_tracker #(.DIV(1), .CNT_INIT(4'd0)) u1 (
    .clk(clk), .rst(rst), .load(ld1), .target(tv1), .start(st1), .clear(cl1),
    .a_gt_b(gt1), .a_lt_b(lt1), .a_eq_b(eq1),
    .cnt(cnt1), .tgt(tgt1), .busy(busy1), .done(done1), .err(err1), .steps(steps1)
  );

  compare_tracker #(.DIV(4), .CNT_INIT(4'd9)) u4 (
    .clk(clk), .rst(rst), .load(ld4), .target(tv4), .start(st4), .clear(cl4),
    .a_gt_b(gt4), .a_lt_b(lt4), .a_eq_b(eq4),
    .cnt(cnt4), .tgt(tgt4), .busy(busy4), .done(done4), .err(err4), .steps(steps4)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step1(input logic l, input logic [3:0] t, input logic s, input logic c);
    ld1 = l; tv1 = t; st1 = s; cl1 = c;
    @(posedge clk); #1;
    ld1 = 1'b0; st1 = 1'b0; cl1 = 1'b0;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       ld;
    logic [3:0] tv;
    logic       st;
    logic       cl;
    logic [3:0] eCnt;
    logic [3:0] eTgt;
    logic       eBusy;
    logic       eDone;
    logic [4:0] eSteps;
  } vec_t;

  localparam int N_VEC = 21;
  vec_t vecs [N_VEC];

  initial begin
    // inputs: ld, tv, st, cl | expected after edge: cnt, tgt, busy, done, steps
    vecs[0]  = '{1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 4'd5, 1'b1, 1'b0, 5'd0};
    vecs[1]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 4'd5, 1'b1, 1'b0, 5'd1};
    vecs[2]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 4'd5, 1'b1, 1'b0, 5'd2};
    vecs[3]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 4'd5, 1'b1, 1'b0, 5'd3};
    vecs[4]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 4'd5, 1'b1, 1'b0, 5'd4};
    vecs[5]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 4'd5, 1'b1, 1'b0, 5'd5};
    vecs[6]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 4'd5, 1'b0, 1'b1, 5'd5};
    vecs[7]  = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 4'd5, 1'b0, 1'b0, 5'd5};
    vecs[8]  = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0, 5'd0};
    vecs[9]  = '{1'b1, 4'd7, 1'b1, 1'b0, 4'd5, 4'd7, 1'b1, 1'b0, 5'd0};
    vecs[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd6, 4'd7, 1'b1, 1'b0, 5'd1};
    vecs[11] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b1, 1'b0, 5'd2};
    vecs[12] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b1, 5'd2};
    vecs[13] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0, 5'd2};
    // already equal at start: done at the first tick, no steps
    vecs[14] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd7, 4'd7, 1'b1, 1'b0, 5'd0};
    vecs[15] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b1, 5'd0};
    vecs[16] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0, 5'd0};
    // clear in TRACK wins over the equality tick: no done pulse
    vecs[17] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd7, 4'd7, 1'b1, 1'b0, 5'd0};
    vecs[18] = '{1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0, 5'd0};
    // clear beats load and start in IDLE
    vecs[19] = '{1'b1, 4'd3, 1'b1, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0, 5'd0};
    vecs[20] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b0, 1'b0, 5'd0};

    // ---------------- reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_cnt1", cnt1, 0);
    chk("rst_cnt4", cnt4, 9);
    chk("rst_tgt1", tgt1, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_err1", err1, 0);
    chk("rst_steps4", steps4, 0);

    // ---------------- table on DIV=1
    for (int i = 0; i < N_VEC; i++) begin
      step1(vecs[i].ld, vecs[i].tv, vecs[i].st, vecs[i].cl);
      chk($sformatf("vec%0d_cnt", i), cnt1, vecs[i].eCnt);
      chk($sformatf("vec%0d_tgt", i), tgt1, vecs[i].eTgt);
      chk($sformatf("vec%0d_busy", i), busy1, vecs[i].eBusy);
      chk($sformatf("vec%0d_done", i), done1, vecs[i].eDone);
      chk($sformatf("vec%0d_steps", i), steps1, vecs[i].eSteps);
      chk($sformatf("vec%0d_err", i), err1, 0);
    end

    // ---------------- DIV=4: 9 -> 3, one step every 4th clock
    ld4 = 1'b1; tv4 = 4'd3; st4 = 1'b1;
    @(posedge clk); #1;
    ld4 = 1'b0; st4 = 1'b0;
    chk("d4_start_tgt", tgt4, 3);
    chk("d4_start_busy", busy4, 1);
    for (int k = 1; k <= 6; k++) begin
      for (int j = 0; j < 3; j++) begin
        @(posedge clk); #1;
        chk($sformatf("d4_hold%0d_cnt", k), cnt4, 4'd10 - 4'(k));
        chk($sformatf("d4_hold%0d_busy", k), busy4, 1);
      end
      @(posedge clk); #1;
      chk($sformatf("d4_step%0d_cnt", k), cnt4, 4'd9 - 4'(k));
      chk($sformatf("d4_step%0d_done", k), done4, 0);
    end
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk("d4_pre_done_busy", busy4, 1);
      chk("d4_pre_done", done4, 0);
    end
    @(posedge clk); #1;
    chk("d4_done", done4, 1);
    chk("d4_done_busy", busy4, 0);
    chk("d4_steps", steps4, 6);
    @(posedge clk); #1;
    chk("d4_done_single", done4, 0);
    chk("d4_final_cnt", cnt4, 3);

    // ---------------- illegal / unusual flag combinations (u1 idle, cnt=7)
    step1(1'b1, 4'd9, 1'b1, 1'b0);
    chk("flg_busy", busy1, 1);
`ifdef CMP_CHECK_EN
    frc1 = 1'b1; fFlags1 = 3'b110;
    edge1();
    frc1 = 1'b0;
    chk("err_set", err1, 1);
    chk("err_busy", busy1, 0);
    chk("err_cnt", cnt1, 7);
    step1(1'b1, 4'd3, 1'b1, 1'b0);
    chk("err_frozen_tgt", tgt1, 9);
    chk("err_frozen_cnt", cnt1, 7);
    chk("err_sticky", err1, 1);
    step1(1'b0, 4'd0, 1'b0, 1'b1);
    chk("err_clear", err1, 0);
    chk("err_clear_busy", busy1, 0);
    chk("err_clear_steps", steps1, 0);
    chk("err_clear_cnt", cnt1, 7);
`else
    frc1 = 1'b1; fFlags1 = 3'b000;
    edge1();
    chk("zero_flags_cnt", cnt1, 7);
    chk("zero_flags_steps", steps1, 0);
    fFlags1 = 3'b110;
    edge1();
    chk("gt_prio_cnt", cnt1, 6);
    chk("gt_prio_steps", steps1, 1);
    fFlags1 = 3'b101;
    edge1();
    chk("eq_prio_done", done1, 1);
    chk("eq_prio_cnt", cnt1, 6);
    frc1 = 1'b0;
    edge1();
    chk("flg_idle_done", done1, 0);
    chk("flg_err_tied", err1, 0);
`endif

    // ---------------- reset mid-TRACK at cnt=4
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    step1(1'b1, 4'd12, 1'b1, 1'b0);
    repeat (4) edge1();
    chk("mid_cnt_before", cnt1, 4);
    chk("mid_busy_before", busy1, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_cnt", cnt1, 0);
    chk("mid_rst_tgt", tgt1, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_steps", steps1, 0);
    chk("mid_rst_cnt4", cnt4, 9);
    @(posedge clk); #1 rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      edge1();
      chk("post_rst_done", done1, 0);
      chk("post_rst_cnt", cnt1, 0);
    end

    // ---------------- retarget: 0 -> 12, tgt becomes 2 as cnt reaches 6
    step1(1'b1, 4'd12, 1'b1, 1'b0);
    chk("rt_start_cnt", cnt1, 0);
    for (int i = 0; i < 10 && cnt1 != 4'd5; i++) edge1();
    chk("rt_reach5", cnt1, 5);
    step1(1'b1, 4'd2, 1'b0, 1'b0);
    chk("rt_cnt6", cnt1, 6);
    chk("rt_tgt2", tgt1, 2);
    chk("rt_steps6", steps1, 6);
    edge1();
    chk("rt_reverse", cnt1, 5);
    for (int i = 0; i < 12 && !done1; i++) edge1();
    chk("rt_done", done1, 1);
    chk("rt_cnt", cnt1, 2);
    chk("rt_steps", steps1, 10);
    edge1();
    chk("rt_done_single", done1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
